// File: rtl/time_pkg.sv
// Shared time-field definitions for the time-base datapath and the FND controller.
//   Field widths, field maxima, packed bit offsets and the packed time payload.
package time_pkg;

  localparam int unsigned HOUR_W = 5;
  localparam int unsigned MIN_W  = 6;
  localparam int unsigned SEC_W  = 6;
  localparam int unsigned MSEC_W = 7;
  localparam int unsigned TIME_W = HOUR_W + MIN_W + SEC_W + MSEC_W;

  localparam int unsigned HOUR_MAX = 23;
  localparam int unsigned MIN_MAX  = 59;
  localparam int unsigned SEC_MAX  = 59;
  localparam int unsigned MSEC_MAX = 99;

  localparam int unsigned MSEC_LSB = 0;
  localparam int unsigned SEC_LSB  = MSEC_LSB + MSEC_W;
  localparam int unsigned MIN_LSB  = SEC_LSB + SEC_W;
  localparam int unsigned HOUR_LSB = MIN_LSB + MIN_W;

  typedef struct packed {
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  min;
    logic [SEC_W-1:0]  sec;
    logic [MSEC_W-1:0] msec;
  } time_t;

  // Increment with compare-to-terminal wrap (operands zero-extended to 8 bits).
  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max_v);
    return (v == max_v) ? 8'd0 : v + 8'd1;
  endfunction

endpackage

// File: rtl/time_chain.sv
// Prescaler plus msec/sec/min/hour counter chain with carry.
// Ports:
//   clk, reset      clock, async active-low reset (loads INIT_HOUR:00:00.00)
//   en              prescaler advance enable
//   clr             clear all fields and the prescaler (highest priority)
//   clr_sub         clear msec field and the prescaler
//   adv             apply one tick to the counter chain
//   hour/min/sec_inc  field increment without carry (overrides carry into that field)
//   tick_c          prescaler at terminal count while enabled (combinational)
//   value           registered counter fields
module time_chain
  import time_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned INIT_HOUR = 0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  clr,
  input  logic  clr_sub,
  input  logic  adv,
  input  logic  hour_inc,
  input  logic  min_inc,
  input  logic  sec_inc,
  output logic  tick_c,
  output time_t value
);

  localparam int unsigned DIV   = CLK_FREQ / TICK_HZ;
  localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TC    = DIV - 1;

  logic [PRE_W-1:0] pre;
  logic             msec_wrap;
  logic             sec_wrap;
  logic             min_wrap;

  assign tick_c = en && (pre == PRE_W'(TC));

  // Prescaler: wraps at terminal count, holds while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
    end else if (clr || clr_sub) begin
      pre <= '0;
    end else if (en) begin
      pre <= tick_c ? '0 : pre + PRE_W'(1);
    end
  end

  assign msec_wrap = adv && (value.msec == MSEC_W'(MSEC_MAX));
  assign sec_wrap  = msec_wrap && (value.sec == SEC_W'(SEC_MAX));
  assign min_wrap  = sec_wrap && (value.min == MIN_W'(MIN_MAX));

  // Counter chain; a field increment request takes the place of the carry into that field.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value.hour <= HOUR_W'(INIT_HOUR);
      value.min  <= '0;
      value.sec  <= '0;
      value.msec <= '0;
    end else if (clr) begin
      value <= '0;
    end else begin
      if (clr_sub) begin
        value.msec <= '0;
      end else if (adv) begin
        value.msec <= MSEC_W'(wrap_inc(8'(value.msec), 8'(MSEC_MAX)));
      end

      if (sec_inc || msec_wrap) begin
        value.sec <= SEC_W'(wrap_inc(8'(value.sec), 8'(SEC_MAX)));
      end

      if (min_inc || sec_wrap) begin
        value.min <= MIN_W'(wrap_inc(8'(value.min), 8'(MIN_MAX)));
      end

      if (hour_inc || min_wrap) begin
        value.hour <= HOUR_W'(wrap_inc(8'(value.hour), 8'(HOUR_MAX)));
      end
    end
  end

endmodule

// File: rtl/time_counter_dp.sv
// Time-base datapath: stopwatch and settable free-running watch, muxed onto o_time.
// Ports:
//   clk, reset            clock, async active-low reset
//   i_mode                0 = stopwatch shown, 1 = watch shown
//   i_run_stop, i_clear   stopwatch toggle / clear pulses (act in either mode)
//   i_hour_up/min_up/sec_up  watch set pulses (act only when i_mode = 1)
//   o_time                {hour,min,sec,msec} of the selected counter (combinational mux)
//   o_running             stopwatch run state (registered)
module time_counter_dp
  import time_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned TICK_HZ    = 100,
  parameter int unsigned WATCH_HOUR = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mode,
  input  logic              i_run_stop,
  input  logic              i_clear,
  input  logic              i_hour_up,
  input  logic              i_min_up,
  input  logic              i_sec_up,
  output logic [TIME_W-1:0] o_time,
  output logic              o_running
);

  logic  run;
  logic  tick_pending;
  logic  sw_tick_c;
  logic  w_tick_c;
  logic  set_hour;
  logic  set_min;
  logic  set_sec;
  logic  set_any;
  logic  w_tick_any;
  logic  w_adv;
  time_t sw_val;
  time_t w_val;

  assign set_hour = i_mode && i_hour_up;
  assign set_min  = i_mode && i_min_up;
  assign set_sec  = i_mode && i_sec_up;
  assign set_any  = set_hour || set_min || set_sec;

  // A watch tick that collides with a set pulse is held one cycle, unless sec_up discards it.
  assign w_tick_any = w_tick_c || tick_pending;
  assign w_adv      = w_tick_any && !set_any;

  // Run state and deferred-tick flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run          <= 1'b0;
      tick_pending <= 1'b0;
    end else begin
      if (i_run_stop) begin
        run <= ~run;
      end
      tick_pending <= w_tick_any && set_any && !set_sec;
    end
  end

  time_chain #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ),
    .INIT_HOUR(0)
  ) u_stopwatch (
    .clk     (clk),
    .reset   (reset),
    .en      (run),
    .clr     (i_clear),
    .clr_sub (1'b0),
    .adv     (sw_tick_c && !i_clear),
    .hour_inc(1'b0),
    .min_inc (1'b0),
    .sec_inc (1'b0),
    .tick_c  (sw_tick_c),
    .value   (sw_val)
  );

  time_chain #(
    .CLK_FREQ (CLK_FREQ),
    .TICK_HZ  (TICK_HZ),
    .INIT_HOUR(WATCH_HOUR)
  ) u_watch (
    .clk     (clk),
    .reset   (reset),
    .en      (1'b1),
    .clr     (1'b0),
    .clr_sub (set_sec),
    .adv     (w_adv),
    .hour_inc(set_hour),
    .min_inc (set_min),
    .sec_inc (set_sec),
    .tick_c  (w_tick_c),
    .value   (w_val)
  );

  assign o_time    = i_mode ? w_val : sw_val;
  assign o_running = run;

endmodule
